stream_source: RTL

//  Programmable valid/ready stream producer; the upstream end feeding pipeline register slices.
//  On start it emits len beats of generated payload, with an optional idle gap after each beat.
//  It obeys downstream backpressure and reports progress, stalls and completion.

---
 rtl/stream_source_pkg.sv | 8 +
 rtl/stream_source_if.sv | 9 +
 rtl/stream_payload_gen.sv | 26 ++
 rtl/stream_source.sv | 72 +++++++
 4 files changed

// File: rtl/stream_source_pkg.sv
// stream_source_pkg: shared FSM states, stall counter width and LFSR taps (used when STREAM_SOURCE_LFSR_EN is defined).
package stream_source_pkg;
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;
   localparam int STALL_CNT_W = 16;
   function automatic logic [31:0] lfsr_taps(input int width);
      return width == 32 ? 32'h8020_0003 : width == 16 ? 32'h0000_B400 : 32'h0000_00B8;
   endfunction
endpackage

// File: rtl/stream_source_if.sv
// stream_source_if: valid/ready stream bundle with producer (master) and consumer (slave) views.
interface stream_source_if #(parameter int DATA_WIDTH = 8);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/stream_payload_gen.sv
// stream_payload_gen: payload register; incrementing counter, or Galois LFSR when STREAM_SOURCE_LFSR_EN is defined.
module stream_payload_gen import stream_source_pkg::*; #(parameter int WIDTH = 8) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] value
);
   logic [WIDTH-1:0] init, nxt;
`ifdef STREAM_SOURCE_LFSR_EN
   localparam logic [31:0] TAPS = lfsr_taps(WIDTH);
   logic [WIDTH-1:0] taps;
   assign taps = TAPS[WIDTH-1:0];
   // an all-zero LFSR state would lock up, so seed 0 maps to all-ones
   assign init = seed == '0 ? '1 : seed;
   assign nxt = value[0] ? (value >> 1) ^ taps : value >> 1;
`else
   assign init = seed;
   assign nxt = value + WIDTH'(1);
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) value <= '0;
      else if (load) value <= init;
      else if (step) value <= nxt;
endmodule

// File: rtl/stream_source.sv
// stream_source: programmable valid/ready producer emitting len beats with optional inter-beat gap.
module stream_source import stream_source_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16,
   parameter int GAP_WIDTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [DATA_WIDTH-1:0]  seed,
   input  logic [LEN_WIDTH-1:0]   len,
   input  logic [GAP_WIDTH-1:0]   gap,
   stream_source_if.master        src,
   output logic                   busy,
   output logic                   done,
   output logic [LEN_WIDTH-1:0]   beat_count,
   output logic [STALL_CNT_W-1:0] stall_count
);
   state_e state, state_d;
   logic [LEN_WIDTH-1:0] len_q;
   logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
   logic abort_q, hs, launch, last, pend;
   logic [DATA_WIDTH-1:0] payload;
   assign hs = src.out_valid & src.out_ready;
   assign launch = state == IDLE && start;
   assign last = beat_count == len_q - LEN_WIDTH'(1);
   assign pend = abort_q | abort;
   assign src.out_valid = state == SEND;
   assign src.out_last = state == SEND && last;
   assign src.out_data = payload;
   assign busy = state != IDLE;
   assign done = state == DONE;
   stream_payload_gen #(.WIDTH(DATA_WIDTH)) u_gen (
      .clk(clk), .rst(rst), .load(launch), .step(hs), .seed(seed), .value(payload)
   );
   always_comb begin
      state_d = state;
      case (state)
         IDLE: state_d = !start ? IDLE : len == '0 ? DONE : SEND;
         SEND: state_d = !hs ? SEND : (last || pend) ? DONE : gap_q != '0 ? GAP : SEND;
         GAP:  state_d = abort ? DONE : gap_cnt == GAP_WIDTH'(1) ? SEND : GAP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         len_q <= '0;
         gap_q <= '0;
         gap_cnt <= '0;
         abort_q <= 1'b0;
         beat_count <= '0;
         stall_count <= '0;
      end else begin
         state <= state_d;
         if (launch) begin
            len_q <= len;
            gap_q <= gap;
            abort_q <= 1'b0;
            beat_count <= '0;
            stall_count <= '0;
         end else begin
            if (state == SEND && abort) abort_q <= 1'b1;
            else if (state == DONE) abort_q <= 1'b0;
            if (hs) beat_count <= beat_count + LEN_WIDTH'(1);
            if (src.out_valid && !src.out_ready && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
            if (state == SEND && hs) gap_cnt <= gap_q;
            else if (state == GAP) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
         end
      end
endmodule
